// File: rtl/ram_rd_sched.sv
// Round-robin arbiter that lets N_REQ burst requesters share one BRAM read port.
// First read goes out one cycle after the request is sampled; data returns RD_LAT later; a burst is never preempted.
module ram_rd_sched #(
    parameter int WIDTH  = 32,
    parameter int N_REQ  = 2,
    parameter int LEN_W  = 8,
    parameter int RD_LAT = 1,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                     i_clk,
    input  logic                     i_n_reset,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ*WIDTH-1:0]   i_base,
    input  logic [N_REQ*LEN_W-1:0]   i_len,
    output logic [N_REQ-1:0]         o_gnt,
    output logic [N_REQ-1:0]         o_done,
    output logic                     o_rst_ram,
    output logic                     o_en_ram,
    output logic [WIDTH-1:0]         o_ram_addr,
    input  logic [WIDTH-1:0]         i_ram_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_valid,
    output logic [ID_W-1:0]          o_valid_id
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    gid;
    logic [WIDTH-1:0]   base_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt;
    logic [LAT_W-1:0]   lat_cnt;
    logic               sel_vld;
    logic [ID_W-1:0]    sel_id;
    logic [WIDTH-1:0]   sel_base;
    logic [LEN_W-1:0]   sel_len;
    logic [RD_LAT-1:0]  vld_sr;
    logic [ID_W-1:0]    id_sr [RD_LAT];

    // Scan downwards so the requester closest at-or-after rr_ptr wins.
    always_comb begin
        logic [ID_W-1:0] idx;
        idx     = '0;
        sel_vld = 1'b0;
        sel_id  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (i_req[idx]) begin
                sel_vld = 1'b1;
                sel_id  = idx;
            end
        end
    end

    assign sel_base = i_base[sel_id*WIDTH +: WIDTH];
    assign sel_len  = i_len[sel_id*LEN_W +: LEN_W];

    // cnt holds the number of words already issued, so word 0 is put out on the grant edge.
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            gid        <= '0;
            base_q     <= '0;
            len_q      <= '0;
            cnt        <= '0;
            lat_cnt    <= '0;
            o_gnt      <= '0;
            o_done     <= '0;
            o_en_ram   <= 1'b0;
            o_ram_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        gid    <= sel_id;
                        base_q <= sel_base;
                        len_q  <= sel_len;
                        o_gnt  <= N_REQ'(1) << sel_id;
                        if (sel_len == '0) begin
                            cnt    <= '0;
                            o_done <= N_REQ'(1) << sel_id;
                            state  <= DONE;
                        end else begin
                            cnt        <= LEN_W'(1);
                            o_en_ram   <= 1'b1;
                            o_ram_addr <= sel_base << 2;
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (!i_req[gid] || cnt == len_q) begin
                        o_en_ram <= 1'b0;
                        lat_cnt  <= '0;
                        state    <= DRAIN;
                    end else begin
                        o_ram_addr <= (base_q + WIDTH'(cnt)) << 2;
                        cnt        <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (lat_cnt == LAT_W'(RD_LAT - 1)) begin
                        o_done <= o_gnt;
                        state  <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                DONE: begin
                    o_done <= '0;
                    o_gnt  <= '0;
                    rr_ptr <= (int'(gid) == N_REQ - 1) ? '0 : gid + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read-return tracking: enable and owner delayed by the BRAM latency.
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            vld_sr <= '0;
            for (int i = 0; i < RD_LAT; i++) id_sr[i] <= '0;
        end else begin
            vld_sr[0] <= o_en_ram;
            id_sr[0]  <= gid;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                id_sr[i]  <= id_sr[i-1];
            end
        end
    end

    assign o_valid    = vld_sr[RD_LAT-1];
    assign o_valid_id = id_sr[RD_LAT-1];
    assign o_data     = i_ram_data;
    assign o_rst_ram  = ~i_n_reset;

endmodule

// File: tb/tb_ram_rd_sched.sv
// Randomized scoreboard bench for ram_rd_sched: expected addresses, beats and done pulses are queued
// by the stimulus from a burst-level model; a negedge monitor pops and compares.
module tb_ram_rd_sched;

    localparam int N  = 3;
    localparam int W  = 32;
    localparam int LW = 8;
    localparam int RL = 1;
    localparam int IW = $clog2(N);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      i_req = '0;
    logic [N*W-1:0]    i_base = '0;
    logic [N*LW-1:0]   i_len = '0;
    logic [N-1:0]      o_gnt, o_done;
    logic              o_rst_ram, o_en_ram, o_valid;
    logic [W-1:0]      o_ram_addr, i_ram_data, o_data;
    logic [IW-1:0]     o_valid_id;

    ram_rd_sched #(.WIDTH(W), .N_REQ(N), .LEN_W(LW), .RD_LAT(RL)) dut (
        .i_clk(clk), .i_n_reset(rst_n), .i_req(i_req), .i_base(i_base), .i_len(i_len),
        .o_gnt(o_gnt), .o_done(o_done), .o_rst_ram(o_rst_ram), .o_en_ram(o_en_ram),
        .o_ram_addr(o_ram_addr), .i_ram_data(i_ram_data), .o_data(o_data),
        .o_valid(o_valid), .o_valid_id(o_valid_id)
    );

    always #5 clk = ~clk;

    typedef struct { int id; logic [31:0] data; } beat_t;
    typedef struct { int id; int len; } done_t;

    logic [31:0] addr_q[$];
    beat_t       beat_q[$];
    done_t       done_q[$];
    int          total = 0;
    int          bad = 0;
    int          rr = 0;
    int          cyc = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [N-1:0] oh(input int id);
        logic [N-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // BRAM model: registered read of a fixed address->data mapping.
    logic [31:0] ram_pipe [RL];
    always @(posedge clk) begin
        if (o_en_ram) ram_pipe[0] <= mem_word(o_ram_addr);
        for (int i = 1; i < RL; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign i_ram_data = ram_pipe[RL-1];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor
    logic [N-1:0] prev_gnt = '0;
    logic         prev_done = 1'b0;
    int           gnt_rise = 0;
    int           last_vld = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_gnt != '0 && prev_gnt == '0) begin
                gnt_rise = cyc;
                if (done_q.size() == 0) check("gnt_unexpected", 64'(o_gnt), 64'd0);
                else check("gnt_onehot", 64'(o_gnt), 64'(oh(done_q[0].id)));
            end
            if (prev_done) check("gnt_drop_after_done", 64'(o_gnt), 64'd0);
            if (o_en_ram) begin
                check("en_has_gnt", 64'(o_gnt != '0), 64'd1);
                if (addr_q.size() == 0) check("en_unexpected", 64'(o_en_ram), 64'd0);
                else check("ram_addr", 64'(o_ram_addr), 64'(addr_q.pop_front()));
            end
            if (o_valid) begin
                if (beat_q.size() == 0) check("valid_unexpected", 64'(o_valid), 64'd0);
                else begin
                    beat_t b;
                    b = beat_q.pop_front();
                    check("valid_id", 64'(o_valid_id), 64'(b.id));
                    check("data", 64'(o_data), 64'(b.data));
                end
                last_vld = cyc;
            end
            if (o_done != '0) begin
                if (done_q.size() == 0) check("done_unexpected", 64'(o_done), 64'd0);
                else begin
                    done_t d;
                    d = done_q.pop_front();
                    check("done_vec", 64'(o_done), 64'(oh(d.id)));
                    check("done_latency", 64'(cyc - gnt_rise), 64'((d.len == 0) ? 0 : d.len + RL));
                    if (d.len > 0) check("done_after_last_valid", 64'(cyc - last_vld), 64'd1);
                end
            end
            prev_gnt  = o_gnt;
            prev_done = (o_done != '0);
        end else begin
            prev_gnt  = '0;
            prev_done = 1'b0;
        end
    end

    task automatic push_burst(input int id, input logic [31:0] base, input int nb);
        for (int i = 0; i < nb; i++) begin
            logic [31:0] a;
            a = (base + 32'(i)) << 2;
            addr_q.push_back(a);
            beat_q.push_back('{id, mem_word(a)});
        end
        done_q.push_back('{id, nb});
        rr = (id + 1) % N;
    endtask

    task automatic set_req(input int id, input logic [31:0] base, input int len);
        i_base[id*W +: W]   = base;
        i_len[id*LW +: LW]  = LW'(len);
    endtask

    task automatic wait_done(input logic [N-1:0] pend_in);
        logic [N-1:0] pend;
        pend = pend_in;
        for (int c = 0; c < 600 && pend != '0; c++) begin
            @(negedge clk);
            if ((o_done & pend) != '0) begin
                pend  = pend & ~o_done;
                i_req = i_req & ~o_done;
            end
        end
        check("done_timeout", 64'(pend), 64'd0);
    endtask

    task automatic wait_en(input int n);
        int seen;
        seen = 0;
        for (int c = 0; c < 100 && seen < n; c++) begin
            @(negedge clk);
            if (o_en_ram) seen++;
        end
        check("en_count_timeout", 64'(seen), 64'(n));
    endtask

    task automatic chk_quiet(input string tag);
        check({tag, "_gnt"},   64'(o_gnt), 64'd0);
        check({tag, "_done"},  64'(o_done), 64'd0);
        check({tag, "_en"},    64'(o_en_ram), 64'd0);
        check({tag, "_addr"},  64'(o_ram_addr), 64'd0);
        check({tag, "_valid"}, 64'(o_valid), 64'd0);
        check({tag, "_vid"},   64'(o_valid_id), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] mask;
        logic [31:0]  bs [N];
        int           ls [N];
        int           id, start, ndone;

        #1;
        check("rst_ram_in_reset", 64'(o_rst_ram), 64'd1);
        chk_quiet("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ram_released", 64'(o_rst_ram), 64'd0);
        chk_quiet("post_reset");

        // Single burst
        set_req(0, 32'h10, 4);
        push_burst(0, 32'h10, 4);
        i_req = 3'b001;
        wait_done(3'b001);

        // Two requesters held continuously: grants alternate
        set_req(0, 32'h100, 2);
        set_req(1, 32'h200, 2);
        for (int b = 0; b < 4; b++) begin
            id = rr;
            while (id > 1) id = (id + 1) % N;
            push_burst(id, (id == 0) ? 32'h100 : 32'h200, 2);
        end
        i_req = 3'b011;
        ndone = 0;
        for (int c = 0; c < 200 && ndone < 4; c++) begin
            @(negedge clk);
            if (o_done != '0) ndone++;
        end
        i_req = '0;
        check("rr_done_count", 64'(ndone), 64'd4);

        // Zero length
        set_req(1, 32'h55, 0);
        push_burst(1, 32'h55, 0);
        i_req = 3'b010;
        wait_done(3'b010);

        // Abort after the third issue cycle
        set_req(0, 32'h3000, 8);
        push_burst(0, 32'h3000, 3);
        i_req = 3'b001;
        wait_en(3);
        i_req = '0;
        wait_done(3'b001);

        // Address wrap
        set_req(0, 32'hFFFF_FFFF, 2);
        push_burst(0, 32'hFFFF_FFFF, 2);
        i_req = 3'b001;
        wait_done(3'b001);

        // Asynchronous reset mid-burst, then pointer must restart at 0
        set_req(0, 32'h500, 6);
        push_burst(0, 32'h500, 6);
        i_req = 3'b001;
        wait_en(3);
        #1;
        rst_n = 1'b0;
        i_req = '0;
        #1;
        check("midrst_rst_ram", 64'(o_rst_ram), 64'd1);
        chk_quiet("midrst");
        addr_q.delete();
        beat_q.delete();
        done_q.delete();
        rr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_quiet("midrst_release");
        set_req(0, 32'h600, 1);
        set_req(1, 32'h700, 1);
        push_burst(0, 32'h600, 1);
        push_burst(1, 32'h700, 1);
        i_req = 3'b011;
        wait_done(3'b011);

        // Random rounds of simultaneous requests
        for (int r = 0; r < 60; r++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int k = 0; k < N; k++) begin
                bs[k] = $urandom;
                ls[k] = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 40) : $urandom_range(0, 9);
                if (mask[k]) set_req(k, bs[k], ls[k]);
            end
            start = rr;
            for (int j = 0; j < N; j++) begin
                id = (start + j) % N;
                if (mask[id]) push_burst(id, bs[id], ls[id]);
            end
            i_req = mask;
            wait_done(mask);
        end

        repeat (10) @(negedge clk);
        check("addr_q_empty", 64'(addr_q.size()), 64'd0);
        check("beat_q_empty", 64'(beat_q.size()), 64'd0);
        check("done_q_empty", 64'(done_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
